// File: rtl/amo_pkg.sv
// Shared encodings and types for the atomic read-modify-write sequencer.
package amo_pkg;

  typedef enum logic [3:0] {
    AMO_OP_LR   = 4'd0,
    AMO_OP_SC   = 4'd1,
    AMO_OP_SWAP = 4'd2,
    AMO_OP_ADD  = 4'd3,
    AMO_OP_XOR  = 4'd4,
    AMO_OP_AND  = 4'd5,
    AMO_OP_OR   = 4'd6,
    AMO_OP_MIN  = 4'd7,
    AMO_OP_MAX  = 4'd8,
    AMO_OP_MINU = 4'd9,
    AMO_OP_MAXU = 4'd10
  } amo_op_e;

  typedef enum logic [2:0] {
    AMO_ST_IDLE    = 3'd0,
    AMO_ST_RD_REQ  = 3'd1,
    AMO_ST_RD_WAIT = 3'd2,
    AMO_ST_WR_REQ  = 3'd3,
    AMO_ST_RESP    = 3'd4
  } amo_state_e;

  // Granule addresses are stored zero-extended to this width regardless of ADDR_W.
  localparam int AMO_RSV_ADDR_W = 64;

  function automatic int amo_granule_shift(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  typedef struct packed {
    logic                      valid;
    logic                      word;
    logic [AMO_RSV_ADDR_W-1:0] granule;
  } amo_rsv_t;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO datapath: new = f(op, old, wdata), with 32-bit word semantics.
module amo_alu
  import amo_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  amo_op_e          op_i,
  input  logic [XLEN-1:0]  old_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic             word_i,
  output logic [XLEN-1:0]  new_o
);

  logic [XLEN-1:0] a_s, b_s, a_u, b_u, res;
  logic            lt_s, lt_u;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    a_s  = word_i ? XLEN'($signed(old_i[31:0]))   : old_i;
    b_s  = word_i ? XLEN'($signed(wdata_i[31:0])) : wdata_i;
    a_u  = word_i ? XLEN'(old_i[31:0])            : old_i;
    b_u  = word_i ? XLEN'(wdata_i[31:0])          : wdata_i;
    lt_s = $signed(a_s) < $signed(b_s);
    lt_u = a_u < b_u;
    res  = old_i;
    unique case (op_i)
      AMO_OP_SWAP: res = wdata_i;
      AMO_OP_ADD:  res = old_i + wdata_i;
      AMO_OP_XOR:  res = old_i ^ wdata_i;
      AMO_OP_AND:  res = old_i & wdata_i;
      AMO_OP_OR:   res = old_i | wdata_i;
      AMO_OP_MIN:  res = lt_s ? old_i : wdata_i;
      AMO_OP_MAX:  res = lt_s ? wdata_i : old_i;
      AMO_OP_MINU: res = lt_u ? old_i : wdata_i;
      AMO_OP_MAXU: res = lt_u ? wdata_i : old_i;
      default:     res = old_i;
    endcase
    // Word results keep only the low 32 bits, sign-extended for the register file.
    new_o = word_i ? XLEN'($signed(res[31:0])) : res;
  end

endmodule

// File: rtl/amo_rmw_unit.sv
// Atomic sequencer between the MEM stage and the data-memory port: LR/SC plus RV-A AMOs.
module amo_rmw_unit
  import amo_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int NHART  = 2,
  parameter int HID_W  = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic              req_word,
  input  logic [HID_W-1:0]  req_hart,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic              mem_req_word,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              flush
);

  localparam int GSHIFT = amo_granule_shift(XLEN);

  function automatic logic [AMO_RSV_ADDR_W-1:0] granule_of(input logic [ADDR_W-1:0] a);
    return (AMO_RSV_ADDR_W'(a) >> GSHIFT) << GSHIFT;
  endfunction

  amo_state_e        state_q, state_d;
  amo_op_e           op_q, op_d, req_op_e;
  logic [HID_W-1:0]  hart_q, hart_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, new_q, new_d, rdata_q, rdata_d;
  logic              word_q, word_d, word_eff;
  amo_rsv_t          rsv_q [NHART];
  amo_rsv_t          rsv_d [NHART];

  logic [AMO_RSV_ADDR_W-1:0] req_gran, addr_gran, snoop_gran;
  logic [XLEN-1:0]           old_ext, alu_new;
  logic                      sc_pass, wr_commit;

  assign req_op_e   = amo_op_e'(req_op);
  assign word_eff   = (XLEN == 32) ? 1'b0 : req_word;
  assign req_gran   = granule_of(req_addr);
  assign addr_gran  = granule_of(addr_q);
  assign snoop_gran = granule_of(snoop_addr);
  assign old_ext    = word_q ? XLEN'($signed(mem_rsp_rdata[31:0])) : mem_rsp_rdata;
  assign wr_commit  = (state_q == AMO_ST_WR_REQ) && mem_req_ready;

  // A same-cycle snoop or flush on the checked granule also fails the SC.
  assign sc_pass = rsv_q[req_hart].valid && (rsv_q[req_hart].granule == req_gran) &&
                   (rsv_q[req_hart].word == word_eff) && !flush &&
                   !(snoop_valid && (snoop_gran == req_gran));

  amo_alu #(.XLEN(XLEN)) u_alu (
    .op_i    (op_q),
    .old_i   (old_ext),
    .wdata_i (wdata_q),
    .word_i  (word_q),
    .new_o   (alu_new)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    hart_d        = hart_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    new_d         = new_q;
    rdata_d       = rdata_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    resp_valid    = 1'b0;
    unique case (state_q)
      AMO_ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op_e;
          hart_d  = req_hart;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          word_d  = word_eff;
          if (req_op_e == AMO_OP_SC) begin
            if (sc_pass) begin
              state_d = AMO_ST_WR_REQ;
            end else begin
              state_d = AMO_ST_RESP;
              rdata_d = XLEN'(1);
            end
          end else begin
            state_d = AMO_ST_RD_REQ;
          end
        end
      end
      AMO_ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = AMO_ST_RD_WAIT;
      end
      AMO_ST_RD_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = old_ext;
          new_d   = alu_new;
          state_d = (op_q == AMO_OP_LR) ? AMO_ST_RESP : AMO_ST_WR_REQ;
        end
      end
      AMO_ST_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) begin
          state_d = AMO_ST_RESP;
          if (op_q == AMO_OP_SC) rdata_d = '0;
        end
      end
      AMO_ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = AMO_ST_IDLE;
      end
      default: state_d = AMO_ST_IDLE;
    endcase
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = (op_q == AMO_OP_SC) ? wdata_q : new_q;
  assign mem_req_word  = word_q;
  assign resp_rdata    = rdata_q;

  // Set first, then apply clears, so any clear source wins over a same-cycle LR set.
  always_comb begin
    rsv_d = rsv_q;
    if ((state_q == AMO_ST_RD_WAIT) && mem_rsp_valid && (op_q == AMO_OP_LR)) begin
      rsv_d[hart_q] = '{valid: 1'b1, word: word_q, granule: addr_gran};
    end
    if ((state_q == AMO_ST_IDLE) && req_valid && (req_op_e == AMO_OP_SC)) begin
      rsv_d[req_hart].valid = 1'b0;
    end
    for (int h = 0; h < NHART; h++) begin
      if (wr_commit && (HID_W'(h) != hart_q) && (rsv_d[h].granule == addr_gran))
        rsv_d[h].valid = 1'b0;
      if (snoop_valid && (rsv_d[h].granule == snoop_gran))
        rsv_d[h].valid = 1'b0;
      if (flush)
        rsv_d[h].valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= AMO_ST_IDLE;
      op_q    <= AMO_OP_LR;
      hart_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= 1'b0;
      new_q   <= '0;
      rdata_q <= '0;
      // NOTE: the reservation table is reset explicitly; stale valid bits would let an SC succeed.
      rsv_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hart_q  <= hart_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      new_q   <= new_d;
      rdata_q <= rdata_d;
      rsv_q   <= rsv_d;
    end
  end

endmodule

// File: tb/tb_amo_rmw_unit.sv
// Directed self-checking bench for amo_rmw_unit (XLEN=64, two harts) with a small memory model.
module tb_amo_rmw_unit;
  import amo_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_word;
  logic [3:0]  req_op;
  logic [0:0]  req_hart;
  logic [31:0] req_addr, mem_req_addr, snoop_addr;
  logic [63:0] req_wdata, mem_req_wdata, mem_rsp_rdata, resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_req_word;
  logic        mem_rsp_valid, resp_valid, snoop_valid, flush;

  int          assertions = 0;
  int          failures   = 0;
  logic [63:0] mem [logic [31:0]];
  logic [63:0] op_rd, op_wdata;
  logic [31:0] op_waddr;
  logic        op_wword;
  int          op_lat, op_nwr;

  amo_rmw_unit #(.XLEN(64), .ADDR_W(32), .NHART(2), .HID_W(1)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_hart(req_hart), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_word(mem_req_word),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'd0;
  endfunction

  // Issues one request from IDLE and services the memory port until resp_valid (cycle 1 = accept cycle).
  task automatic run_op(input logic [3:0] op, input logic h, input logic [31:0] a,
                        input logic [63:0] wd, input logic w, input bit flush_rdwait);
    logic        rsp_pend = 1'b0;
    logic [63:0] rsp_data = '0;
    logic [63:0] tmp;
    bit          done = 1'b0;
    op_rd = '0; op_lat = 0; op_nwr = 0; op_waddr = '0; op_wdata = '0; op_wword = 1'b0;
    req_valid = 1'b1; req_op = op; req_hart = h; req_addr = a; req_wdata = wd; req_word = w;
    mem_req_ready = 1'b1;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c > 1) req_valid = 1'b0;
      mem_rsp_valid = rsp_pend;
      mem_rsp_rdata = rsp_data;
      flush         = flush_rdwait && rsp_pend;
      rsp_pend      = 1'b0;
      if (resp_valid) begin
        op_rd = resp_rdata; op_lat = c; done = 1'b1;
      end else if (mem_req_valid) begin
        if (mem_req_we) begin
          tmp = rd_mem(mem_req_addr);
          if (mem_req_word) tmp[31:0] = mem_req_wdata[31:0];
          else              tmp       = mem_req_wdata;
          mem[mem_req_addr] = tmp;
          op_nwr++; op_waddr = mem_req_addr; op_wdata = mem_req_wdata; op_wword = mem_req_word;
        end else begin
          rsp_pend = 1'b1;
          rsp_data = rd_mem(mem_req_addr);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0; mem_rsp_valid = 1'b0; flush = 1'b0;
    if (!done) begin
      assertions++; failures++;
      $display("FAIL op_timeout: op %0d addr %h got no resp_valid within 40 cycles", op, a);
    end
  endtask

  task automatic pulse_snoop(input logic [31:0] a);
    snoop_valid = 1'b1; snoop_addr = a;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    assertions++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    assertions++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    assertions++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    assertions++; if (resp_rdata !== 64'd0) begin failures++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_amo_add();
    mem[32'h100] = 64'd5;
    run_op(AMO_OP_ADD, 1'b0, 32'h100, 64'd3, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd5) begin failures++; $display("FAIL add_rdata: got %h expected 5", op_rd); end
    assertions++; if (op_lat !== 5) begin failures++; $display("FAIL add_latency: got %0d expected 5", op_lat); end
    assertions++; if (op_nwr !== 1 || op_waddr !== 32'h100) begin failures++; $display("FAIL add_write: got %0d writes at %h expected 1 at 100", op_nwr, op_waddr); end
    assertions++; if (rd_mem(32'h100) !== 64'd8) begin failures++; $display("FAIL add_mem: got %h expected 8", rd_mem(32'h100)); end
  endtask

  task automatic test_word_minmax();
    mem[32'h400] = 64'h0000_0000_FFFF_FFFF;
    run_op(AMO_OP_MIN, 1'b0, 32'h400, 64'd2, 1'b1, 1'b0);
    assertions++; if (op_rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL minw_rdata: got %h expected ffffffffffffffff", op_rd); end
    assertions++; if (op_wdata[31:0] !== 32'hFFFF_FFFF || op_wword !== 1'b1) begin failures++; $display("FAIL minw_write: got %h word %b expected ffffffff word 1", op_wdata[31:0], op_wword); end
    mem[32'h400] = 64'h0000_0000_FFFF_FFFF;
    run_op(AMO_OP_MINU, 1'b0, 32'h400, 64'd2, 1'b1, 1'b0);
    assertions++; if (op_rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL minuw_rdata: got %h expected ffffffffffffffff", op_rd); end
    assertions++; if (rd_mem(32'h400) !== 64'd2) begin failures++; $display("FAIL minuw_mem: got %h expected 2", rd_mem(32'h400)); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        w;
    logic [63:0] m;
    logic [63:0] b;
    logic [63:0] exp_rd;
    logic [63:0] exp_mem;
  } vec_t;

  task automatic test_alu_ops();
    vec_t vt [10];
    vt[0] = '{AMO_OP_SWAP, 1'b0, 64'h1234, 64'hABCD, 64'h1234, 64'hABCD};
    vt[1] = '{AMO_OP_XOR,  1'b0, 64'hF0F0, 64'h0FF0, 64'hF0F0, 64'hFF00};
    vt[2] = '{AMO_OP_AND,  1'b0, 64'hF0F0, 64'h0FF0, 64'hF0F0, 64'h00F0};
    vt[3] = '{AMO_OP_OR,   1'b0, 64'hF0F0, 64'h0FF0, 64'hF0F0, 64'hFFF0};
    vt[4] = '{AMO_OP_MAX,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3};
    vt[5] = '{AMO_OP_MAXU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB};
    vt[6] = '{AMO_OP_MIN,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB};
    vt[7] = '{AMO_OP_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 64'h7FFF_FFFF, 64'h8000_0000};
    vt[8] = '{AMO_OP_MAXU, 1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000};
    vt[9] = '{AMO_OP_MAX,  1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'd1};
    for (int i = 0; i < 10; i++) begin
      mem[32'h500] = vt[i].m;
      run_op(vt[i].op, 1'b0, 32'h500, vt[i].b, vt[i].w, 1'b0);
      assertions++; if (op_rd !== vt[i].exp_rd) begin failures++; $display("FAIL alu_rdata[%0d]: got %h expected %h", i, op_rd, vt[i].exp_rd); end
      assertions++; if (rd_mem(32'h500) !== vt[i].exp_mem) begin failures++; $display("FAIL alu_mem[%0d]: got %h expected %h", i, rd_mem(32'h500), vt[i].exp_mem); end
    end
  endtask

  task automatic test_lr_sc();
    mem[32'h200] = 64'h11;
    run_op(AMO_OP_LR, 1'b0, 32'h200, 64'd0, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'h11 || op_nwr !== 0) begin failures++; $display("FAIL lr_rdata: got %h with %0d writes expected 11 with 0", op_rd, op_nwr); end
    assertions++; if (op_lat !== 4) begin failures++; $display("FAIL lr_latency: got %0d expected 4", op_lat); end
    run_op(AMO_OP_SC, 1'b0, 32'h200, 64'd7, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd0) begin failures++; $display("FAIL sc_ok_rdata: got %h expected 0", op_rd); end
    assertions++; if (rd_mem(32'h200) !== 64'd7 || op_nwr !== 1) begin failures++; $display("FAIL sc_ok_mem: got %h with %0d writes expected 7 with 1", rd_mem(32'h200), op_nwr); end
    assertions++; if (op_lat !== 3) begin failures++; $display("FAIL sc_ok_latency: got %0d expected 3", op_lat); end
    run_op(AMO_OP_SC, 1'b0, 32'h200, 64'd9, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd1 || op_nwr !== 0) begin failures++; $display("FAIL sc_again: got %h with %0d writes expected 1 with 0", op_rd, op_nwr); end
    assertions++; if (op_lat !== 2) begin failures++; $display("FAIL sc_fail_latency: got %0d expected 2", op_lat); end
  endtask

  task automatic test_snoop();
    run_op(AMO_OP_LR, 1'b0, 32'h200, 64'd0, 1'b0, 1'b0);
    pulse_snoop(32'h204);
    run_op(AMO_OP_SC, 1'b0, 32'h200, 64'd5, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd1 || op_nwr !== 0) begin failures++; $display("FAIL snoop_same_granule: got %h with %0d writes expected 1 with 0", op_rd, op_nwr); end
    run_op(AMO_OP_LR, 1'b0, 32'h200, 64'd0, 1'b0, 1'b0);
    pulse_snoop(32'h208);
    run_op(AMO_OP_SC, 1'b0, 32'h200, 64'd6, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd0 || rd_mem(32'h200) !== 64'd6) begin failures++; $display("FAIL snoop_other_granule: got %h mem %h expected 0 mem 6", op_rd, rd_mem(32'h200)); end
  endtask

  task automatic test_cross_hart();
    mem[32'h300] = 64'h33;
    run_op(AMO_OP_LR, 1'b1, 32'h300, 64'd0, 1'b0, 1'b0);
    run_op(AMO_OP_SWAP, 1'b0, 32'h300, 64'h44, 1'b0, 1'b0);
    run_op(AMO_OP_SC, 1'b1, 32'h300, 64'h55, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd1 || rd_mem(32'h300) !== 64'h44) begin failures++; $display("FAIL cross_hart_sc: got %h mem %h expected 1 mem 44", op_rd, rd_mem(32'h300)); end
    run_op(AMO_OP_LR, 1'b0, 32'h600, 64'd0, 1'b1, 1'b0);
    run_op(AMO_OP_SC, 1'b0, 32'h600, 64'h66, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd1 || op_nwr !== 0) begin failures++; $display("FAIL width_mismatch_sc: got %h with %0d writes expected 1 with 0", op_rd, op_nwr); end
  endtask

  task automatic test_reset_mid_op();
    mem[32'h200] = 64'h77;
    run_op(AMO_OP_LR, 1'b0, 32'h200, 64'd0, 1'b0, 1'b0);
    mem_req_ready = 1'b0;
    req_valid = 1'b1; req_op = AMO_OP_SWAP; req_hart = 1'b0; req_addr = 32'h200;
    req_wdata = 64'hDEAD; req_word = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    assertions++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0) begin failures++; $display("FAIL stall_rd_req: got valid %b we %b expected 1 0", mem_req_valid, mem_req_we); end
    rstn = 1'b0;
    @(negedge clk);
    assertions++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: got ready %b mem_valid %b expected 1 0", req_ready, mem_req_valid); end
    rstn = 1'b1; mem_req_ready = 1'b1;
    @(negedge clk);
    assertions++; if (rd_mem(32'h200) !== 64'h77) begin failures++; $display("FAIL mid_reset_mem: got %h expected 77", rd_mem(32'h200)); end
    run_op(AMO_OP_SC, 1'b0, 32'h200, 64'h88, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd1 || op_nwr !== 0) begin failures++; $display("FAIL mid_reset_sc: got %h with %0d writes expected 1 with 0", op_rd, op_nwr); end
  endtask

  task automatic test_flush();
    mem[32'h700] = 64'h99;
    run_op(AMO_OP_LR, 1'b0, 32'h700, 64'd0, 1'b0, 1'b1);
    assertions++; if (op_rd !== 64'h99) begin failures++; $display("FAIL flush_lr_rdata: got %h expected 99", op_rd); end
    run_op(AMO_OP_SC, 1'b0, 32'h700, 64'hAA, 1'b0, 1'b0);
    assertions++; if (op_rd !== 64'd1 || rd_mem(32'h700) !== 64'h99) begin failures++; $display("FAIL flush_sc: got %h mem %h expected 1 mem 99", op_rd, rd_mem(32'h700)); end
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_word = 1'b0; req_hart = '0;
    req_addr = '0; req_wdata = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0; snoop_valid = 1'b0; snoop_addr = '0; flush = 1'b0;
    test_reset();
    test_amo_add();
    test_word_minmax();
    test_alu_ops();
    test_lr_sc();
    test_snoop();
    test_cross_hart();
    test_reset_mid_op();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/amo_rmw_unit.md
Name: amo_rmw_unit

Overview:
- Parametrised successor to the pipeline AMO controller; a standalone atomic sequencer between the MEM stage and the data-memory port.
- Executes LR, SC and the full RV-A read-modify-write set (SWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU) in word or XLEN width.
- Keeps one LR reservation per hart (NHART channels); reservations are invalidated by own stores, snooped foreign stores and flush.
- Returns the old memory value, or the SC status, on a single response channel.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- ADDR_W, 32, byte address width.
- NHART, 2, number of reservation entries / requesting harts.
- HID_W, 1, hart id width, equal to clog2(NHART), minimum 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-low.
- req_valid  in  1  atomic request valid.
- req_ready  out  1  unit can accept a request (state IDLE).
- req_op  in  4  opcode: LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
- req_word  in  1  32-bit operation (ignored when XLEN=32).
- req_hart  in  HID_W  requesting hart.
- req_addr  in  ADDR_W  naturally aligned address.
- req_wdata  in  XLEN  rs2 operand.
- mem_req_valid  out  1  memory access valid.
- mem_req_ready  in  1  memory accepts the access.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  ADDR_W  access address.
- mem_req_wdata  out  XLEN  write data.
- mem_req_word  out  1  32-bit access size.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_rdata  in  XLEN  read data.
- resp_valid  out  1  result valid, one cycle, no backpressure.
- resp_rdata  out  XLEN  rd value.
- snoop_valid  in  1  store by another agent.
- snoop_addr  in  ADDR_W  snooped store address.
- flush  in  1  clear all reservations (trap/context switch).

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; all reservations invalid; req_ready=1; mem_req_valid=0; resp_valid=0; resp_rdata=0.
- Reset mid-operation aborts immediately with no write issued.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE: req_ready=1. On req_valid, latch op, hart, addr, wdata and word into registers. Next state:
  - SC with reservation check failing: RESP.
  - SC with check passing: WR_REQ.
  - Everything else: RD_REQ.
- RD_REQ: mem_req_valid=1, we=0. Hold the access until mem_req_ready, then go to RD_WAIT.
- RD_WAIT: wait for mem_rsp_valid and capture rdata as old (sign-extended from bit 31 when word). Next state: LR goes to RESP; AMO computes new = f(old, wdata) and goes to WR_REQ.
- WR_REQ: mem_req_valid=1, we=1, wdata = new (AMO) or latched wdata (SC). Hold until mem_req_ready, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata = old for LR and AMO.
  - resp_rdata = 0 for SC success, 1 for SC failure.
- Minimum latency with ready and rsp in the next cycle:
  - LR: 4 cycles from accept to resp.
  - AMO: 5 cycles.
  - SC fail: 2 cycles.
- Word ops:
  - ALU operates on the low 32 bits.
  - MIN/MAX compare signed-32; MINU/MAXU compare unsigned-32.
  - Result is written as 32 bits.
- Reservation entry per hart = {valid, granule address, word flag}.
  - Granule = addr with the low log2(XLEN/8) bits cleared.
- LR sets its hart's entry in the RD_WAIT capture cycle.
- SC check passes only if all hold: entry valid, granule match, word flag match.
- Any SC (pass or fail) clears its own hart's entry at the IDLE decision.
- Own write commit (WR_REQ handshake) clears every other hart's entry with a matching granule.
- snoop_valid clears every entry with a matching granule.
- flush clears all entries.
- Same-cycle conflicts: any clear source (snoop, flush, own-write) beats an LR set on the same hart/granule, so the entry ends invalid.
- Requests while not IDLE are not accepted (req_ready=0); the requester holds.
- Misaligned addresses: alignment is the upstream responsibility; the unit does not check.

Decomposition:
- Shared package amo_pkg, containing:
  - op encodings (AMO_OP_*)
  - FSM state encodings (AMO_ST_*)
  - XLEN-dependent granule shift constant
  - reservation entry struct/typedef
- One natural sub-module: amo_alu.
  - Combinational f(op, old, wdata, word) -> new, including word sign-extension.

Test Plan:
- XLEN=64: mem[0x100]=5, AMOADD.D hart0 wdata=3 → read at 0x100, write 8, resp_rdata=5, 5 cycles with ready=1.
- AMOMIN.W on 0xFFFFFFFF(-1) vs 2 → write 0xFFFFFFFF, resp_rdata=0xFFFFFFFFFFFFFFFF. AMOMINU.W on the same values → write 2.
- LR.D hart0 @0x200, then SC.D hart0 @0x200 wdata=7 → mem=7, resp_rdata=0. A second SC → resp_rdata=1 with no memory write.
- LR hart0 @0x200, snoop @0x204 (same granule) → SC fails. With snoop @0x208 instead → SC succeeds.
- LR hart1 @0x300, AMOSWAP by hart0 @0x300 → hart1 SC fails. Separately: LR.W then SC.D at the same address → fails on width mismatch.
- Hold mem_req_ready=0 for 3 cycles in RD_REQ, then assert rstn=0 → state IDLE, no write issued, a subsequent SC fails. Also: flush during RD_WAIT of an LR → reservation invalid.
